exc_ctrl: RTL and testbench



---
 rtl/exc_ctrl_if.sv | 44 ++++
 rtl/exc_ctrl.sv | 119 +++++++++++
 tb/tb_exc_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/exc_ctrl_if.sv
// MEM-stage / CP0 bundle seen by the exception arbiter.
// slave: the arbiter itself. master: the pipeline/CP0 side that drives it.
interface exc_ctrl_if;
  // MEM-stage instruction and its raw exception flags
  logic        mem_valid;
  logic        mem_stall;
  logic [31:0] mem_pc;
  logic [31:0] mem_addr;
  logic        mem_delayslot;
  logic        adel_if, ri, ov, sys, bp, adel_ld, ades, eret;
  // interrupt sources and current CP0 state
  logic [5:0]  int_lines;
  logic        timer_int;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  // commit strobes toward CP0
  logic        syscall_s, break_s, overflow_s, reserved_inst_s;
  logic        adel_s, ades_s, eret_s, int_s;
  logic        delayslot;
  logic [31:0] pc;
  logic [31:0] badvaddr;
  logic [5:0]  int_sync;
  // pipeline control
  logic        flush;
  logic        redirect;
  logic [31:0] new_pc;

  modport slave (
    input  mem_valid, mem_stall, mem_pc, mem_addr, mem_delayslot,
           adel_if, ri, ov, sys, bp, adel_ld, ades, eret,
           int_lines, timer_int, cp0_status, cp0_cause, cp0_epc,
    output syscall_s, break_s, overflow_s, reserved_inst_s,
           adel_s, ades_s, eret_s, int_s, delayslot, pc, badvaddr,
           int_sync, flush, redirect, new_pc
  );

  modport master (
    output mem_valid, mem_stall, mem_pc, mem_addr, mem_delayslot,
           adel_if, ri, ov, sys, bp, adel_ld, ades, eret,
           int_lines, timer_int, cp0_status, cp0_cause, cp0_epc,
    input  syscall_s, break_s, overflow_s, reserved_inst_s,
           adel_s, ades_s, eret_s, int_s, delayslot, pc, badvaddr,
           int_sync, flush, redirect, new_pc
  );
endinterface

// File: rtl/exc_ctrl.sv
// MEM-stage exception arbiter. Picks at most one event per cycle, hands the
// one-hot strobe, PC and BadVAddr to CP0 combinationally, then runs a fixed
// length flush followed by a one-cycle redirect to the handler or EPC.
module exc_ctrl #(
  parameter logic [31:0] EXC_ENTRY    = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input logic       clk,
  input logic       rst,
  exc_ctrl_if.slave bus
);

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;
  logic [5:0]  sync1_q, sync1_d, sync2_q, sync2_d;

  logic [5:0]  int_sync;
  logic        irq, commit, any_ev;
  logic        ev_int, ev_adel_if, ev_ri, ev_ov, ev_sys, ev_bp;
  logic        ev_adel_ld, ev_ades, ev_eret;
  logic [31:0] bad_sel;

  // timer interrupt bypasses the synchronizer; it is already in clk domain
  assign int_sync = {sync2_q[5] | bus.timer_int, sync2_q[4:0]};

  assign irq = bus.cp0_status[0] & ~bus.cp0_status[1] &
               (|({int_sync, bus.cp0_cause[9:8]} & bus.cp0_status[15:8]));

  // reset also blocks commit so nothing leaks into CP0 while held in reset
  assign commit = bus.mem_valid & ~bus.mem_stall & (state_q == IDLE) & ~rst;

  // priority pick: exactly one event wins, BadVAddr follows the winner
  always_comb begin
    ev_int = 1'b0; ev_adel_if = 1'b0; ev_ri = 1'b0; ev_ov = 1'b0;
    ev_sys = 1'b0; ev_bp = 1'b0; ev_adel_ld = 1'b0; ev_ades = 1'b0;
    ev_eret = 1'b0;
    bad_sel = 32'h0;
    if (irq)              ev_int = 1'b1;
    else if (bus.adel_if) begin ev_adel_if = 1'b1; bad_sel = bus.mem_pc; end
    else if (bus.ri)      ev_ri = 1'b1;
    else if (bus.ov)      ev_ov = 1'b1;
    else if (bus.sys)     ev_sys = 1'b1;
    else if (bus.bp)      ev_bp = 1'b1;
    else if (bus.adel_ld) begin ev_adel_ld = 1'b1; bad_sel = bus.mem_addr; end
    else if (bus.ades)    begin ev_ades = 1'b1; bad_sel = bus.mem_addr; end
    else if (bus.eret)    ev_eret = 1'b1;
  end

  assign any_ev = ev_int | ev_adel_if | ev_ri | ev_ov | ev_sys | ev_bp |
                  ev_adel_ld | ev_ades | ev_eret;

  // commit-cycle outputs to CP0, all zero when nothing commits
  assign bus.int_s           = commit & ev_int;
  assign bus.adel_s          = commit & (ev_adel_if | ev_adel_ld);
  assign bus.reserved_inst_s = commit & ev_ri;
  assign bus.overflow_s      = commit & ev_ov;
  assign bus.syscall_s       = commit & ev_sys;
  assign bus.break_s         = commit & ev_bp;
  assign bus.ades_s          = commit & ev_ades;
  assign bus.eret_s          = commit & ev_eret;
  assign bus.badvaddr        = commit ? bad_sel : 32'h0;
  assign bus.pc              = bus.mem_pc;
  assign bus.delayslot       = bus.mem_delayslot;
  assign bus.int_sync        = int_sync;

  // flush/redirect are decoded from state; reset masks them immediately
  assign bus.flush    = (state_q == FLUSH) & ~rst;
  assign bus.redirect = (state_q == FLUSH) & (cnt_q == 4'd0) & ~rst;
  assign bus.new_pc   = target_q;

  // next state: latch target at commit, count down the flush window
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    sync1_d  = bus.int_lines;
    sync2_d  = sync1_q;
    case (state_q)
      IDLE: begin
        if (commit && any_ev) begin
          state_d  = FLUSH;
          cnt_d    = 4'(FLUSH_CYCLES - 1);
          target_d = ev_eret ? bus.cp0_epc : EXC_ENTRY;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, counter, target and synchronizer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      target_q <= 32'h0;
      sync1_q  <= 6'h0;
      sync2_q  <= 6'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
    end
  end

  // CP0 fields this block does not look at
  logic unused_cp0;
  assign unused_cp0 = &{1'b0, bus.cp0_status[31:16], bus.cp0_status[7:2],
                        bus.cp0_cause[31:10], bus.cp0_cause[7:0]};

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl with hand-computed expectations.
module tb_exc_ctrl;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;

  localparam logic [7:0] S_INT = 8'h80, S_ADEL = 8'h40, S_ADES = 8'h20,
                         S_OV = 8'h10, S_RI = 8'h08, S_SYS = 8'h04,
                         S_BP = 8'h02, S_ERET = 8'h01, S_NONE = 8'h00;

  exc_ctrl_if bus_if ();

  exc_ctrl #(.EXC_ENTRY(32'hBFC00380), .FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] strobes();
    return {bus_if.int_s, bus_if.adel_s, bus_if.ades_s, bus_if.overflow_s,
            bus_if.reserved_inst_s, bus_if.syscall_s, bus_if.break_s,
            bus_if.eret_s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // inputs change 1ns after the edge; checks happen mid-cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clr_flags();
    bus_if.mem_valid = 0; bus_if.mem_stall = 0; bus_if.mem_delayslot = 0;
    bus_if.adel_if = 0; bus_if.ri = 0; bus_if.ov = 0; bus_if.sys = 0;
    bus_if.bp = 0; bus_if.adel_ld = 0; bus_if.ades = 0; bus_if.eret = 0;
  endtask

  initial begin
    rst = 1;
    clr_flags();
    bus_if.mem_pc = 0; bus_if.mem_addr = 0;
    bus_if.int_lines = 0; bus_if.timer_int = 0;
    bus_if.cp0_status = 0; bus_if.cp0_cause = 0; bus_if.cp0_epc = 0;
    tick(); tick();
    settle();
    chk("rst_strobes", 32'(strobes()), 32'(S_NONE));
    chk("rst_flush", 32'(bus_if.flush), 32'd0);
    chk("rst_redirect", 32'(bus_if.redirect), 32'd0);
    chk("rst_new_pc", bus_if.new_pc, 32'h0);
    chk("rst_int_sync", 32'(bus_if.int_sync), 32'd0);
    tick();
    rst = 0;

    // overflow: commit, 2 flush cycles, redirect in the second
    bus_if.mem_valid = 1; bus_if.ov = 1; bus_if.mem_pc = 32'h8000_0010;
    bus_if.mem_delayslot = 1;
    settle();
    chk("ov_strobe", 32'(strobes()), 32'(S_OV));
    chk("ov_pc", bus_if.pc, 32'h8000_0010);
    chk("ov_delayslot", 32'(bus_if.delayslot), 32'd1);
    chk("ov_badvaddr", bus_if.badvaddr, 32'h0);
    chk("ov_no_flush_yet", 32'(bus_if.flush), 32'd0);
    tick(); clr_flags(); settle();
    chk("ov_flush1", 32'(bus_if.flush), 32'd1);
    chk("ov_redir1", 32'(bus_if.redirect), 32'd0);
    tick(); settle();
    chk("ov_flush2", 32'(bus_if.flush), 32'd1);
    chk("ov_redir2", 32'(bus_if.redirect), 32'd1);
    chk("ov_new_pc", bus_if.new_pc, 32'hBFC00380);
    tick(); settle();
    chk("ov_flush_done", 32'(bus_if.flush), 32'd0);
    chk("ov_redir_done", 32'(bus_if.redirect), 32'd0);
    chk("ov_new_pc_hold", bus_if.new_pc, 32'hBFC00380);

    // adel_ld over ades, BadVAddr from address
    bus_if.mem_valid = 1; bus_if.adel_ld = 1; bus_if.ades = 1;
    bus_if.mem_addr = 32'h0000_0003;
    settle();
    chk("adel_ld_strobe", 32'(strobes()), 32'(S_ADEL));
    chk("adel_ld_bva", bus_if.badvaddr, 32'h3);
    tick(); clr_flags(); tick(); tick();
    // adel_if takes BadVAddr from PC
    bus_if.mem_valid = 1; bus_if.adel_if = 1; bus_if.adel_ld = 1;
    bus_if.mem_pc = 32'h8000_0002;
    settle();
    chk("adel_if_strobe", 32'(strobes()), 32'(S_ADEL));
    chk("adel_if_bva", bus_if.badvaddr, 32'h8000_0002);
    tick(); clr_flags(); tick(); tick();

    // interrupt through the 2-flop synchronizer
    bus_if.cp0_status = 32'h0000_0401;
    bus_if.int_lines = 6'b000001; bus_if.mem_valid = 1;
    bus_if.mem_pc = 32'h8000_0040;
    settle();
    chk("int_c0", 32'(strobes()), 32'(S_NONE));
    tick(); settle();
    chk("int_c1", 32'(strobes()), 32'(S_NONE));
    tick(); settle();
    chk("int_sync", 32'(bus_if.int_sync), 32'h01);
    chk("int_c2", 32'(strobes()), 32'(S_INT));
    chk("int_pc", bus_if.pc, 32'h8000_0040);
    tick(); clr_flags(); bus_if.int_lines = 0; tick(); tick();
    // EXL masks the same request
    bus_if.cp0_status = 32'h0000_0403;
    bus_if.int_lines = 6'b000001; bus_if.mem_valid = 1;
    tick(); tick(); settle();
    chk("exl_sync", 32'(bus_if.int_sync), 32'h01);
    chk("exl_no_int", 32'(strobes()), 32'(S_NONE));
    tick(); settle();
    chk("exl_no_flush", 32'(bus_if.flush), 32'd0);
    clr_flags(); bus_if.int_lines = 0; tick(); tick();

    // interrupt beats syscall in the same cycle
    bus_if.cp0_status = 32'h0000_0401;
    bus_if.int_lines = 6'b000001;
    tick(); tick();
    bus_if.mem_valid = 1; bus_if.sys = 1;
    settle();
    chk("int_vs_sys", 32'(strobes()), 32'(S_INT));
    tick(); clr_flags(); bus_if.int_lines = 0; settle();
    chk("int_vs_sys_flush", 32'(bus_if.flush), 32'd1);
    tick(); settle();
    chk("int_vs_sys_target", bus_if.new_pc, 32'hBFC00380);
    tick(); tick();
    bus_if.cp0_status = 0;

    // eret to EPC; a break during flush is ignored
    bus_if.mem_valid = 1; bus_if.eret = 1; bus_if.cp0_epc = 32'h8000_0100;
    settle();
    chk("eret_strobe", 32'(strobes()), 32'(S_ERET));
    tick(); clr_flags(); bus_if.mem_valid = 1; bus_if.bp = 1;
    bus_if.cp0_epc = 32'h1234_5678;
    settle();
    chk("bp_in_flush", 32'(strobes()), 32'(S_NONE));
    tick(); settle();
    chk("eret_redirect", 32'(bus_if.redirect), 32'd1);
    chk("eret_new_pc", bus_if.new_pc, 32'h8000_0100);
    chk("bp_in_flush2", 32'(strobes()), 32'(S_NONE));
    clr_flags();
    tick();

    // stall holds off commit
    bus_if.mem_valid = 1; bus_if.ri = 1; bus_if.mem_stall = 1;
    settle();
    chk("stall_c0", 32'(strobes()), 32'(S_NONE));
    tick(); settle();
    chk("stall_c1", 32'(strobes()), 32'(S_NONE));
    tick(); settle();
    chk("stall_c2", 32'(strobes()), 32'(S_NONE));
    chk("stall_no_flush", 32'(bus_if.flush), 32'd0);
    tick(); bus_if.mem_stall = 0; settle();
    chk("ri_strobe", 32'(strobes()), 32'(S_RI));
    tick(); clr_flags(); settle();
    chk("ri_flush", 32'(bus_if.flush), 32'd1);
    // reset mid-flush: no redirect afterwards
    rst = 1;
    tick(); rst = 0; settle();
    chk("rst_mid_flush", 32'(bus_if.flush), 32'd0);
    chk("rst_mid_redir", 32'(bus_if.redirect), 32'd0);
    tick(); settle();
    chk("rst_after_flush", 32'(bus_if.flush), 32'd0);
    chk("rst_after_redir", 32'(bus_if.redirect), 32'd0);
    chk("rst_after_new_pc", bus_if.new_pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
